// File: rtl/io_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, plus a 10-bit LED register, on the IO write half.
// Latency: a UART_DATA store at edge N into an empty FIFO with the line idle drops tx at edge N+1.
// Backpressure: none toward the CPU; a store into a full FIFO is dropped and sets a sticky overflow flag.

// Small generic FIFO: valid/ready on both sides, pointers wrap modulo DEPTH (power of two).
module io_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // full/empty come straight from the registered count, so a push is judged on pre-edge occupancy
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_rdy = !full;
  assign pop_vld  = !empty;
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;

  // byte storage; contents are only ever observed through count, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module io_uart_tx_mmio #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic [9:0]  leds
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [8:0] ADDR_UART_DATA = 9'h140;
  localparam logic [8:0] ADDR_UART_STAT = 9'h144;
  localparam logic [8:0] ADDR_LED       = 9'h180;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          overflow;
  logic          busy;

  logic          sel_data;
  logic          sel_stat;
  logic          sel_led;

  logic          push_vld;
  logic          push_rdy;
  logic          pop_vld;
  logic          pop_rdy;
  logic [7:0]    pop_dat;
  logic          fifo_full;
  logic          fifo_empty;

  // only Address[8:0] takes part in decode; WriteData above bit 9 is never stored
  logic          addr_unused;
  assign addr_unused = ^{Address[31:9], WriteData[31:10]};

  assign sel_data = (Address[8:0] == ADDR_UART_DATA);
  assign sel_stat = (Address[8:0] == ADDR_UART_STAT);
  assign sel_led  = (Address[8:0] == ADDR_LED);

  assign push_vld = MemWrite && sel_data;
  assign pop_rdy  = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  io_uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push_vld),
    .push_dat (WriteData[7:0]),
    .push_rdy (push_rdy),
    .pop_vld  (pop_vld),
    .pop_rdy  (pop_rdy),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // readback mux; unselected addresses read as zero so the result can be ORed onto the IO bus
  always_comb begin
    ReadData = '0;
    if (sel_stat) begin
      ReadData = {28'b0, overflow, fifo_empty, fifo_full, busy};
    end else if (sel_led) begin
      ReadData = {22'b0, leds};
    end
  end

  // sticky overflow: set by a push that finds the FIFO full, cleared by any STAT store
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (MemWrite && sel_stat) begin
      overflow <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      overflow <= 1'b1;
    end
  end

  // LED register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds <= '0;
    end else if (MemWrite && sel_led) begin
      leds <= WriteData[9:0];
    end
  end

  // 8N1 transmit sequencer; tx is registered and the shift register is consumed LSB first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop_vld) begin
            // the pop and the falling start edge share this clock edge
            shift <= pop_dat;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
